// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one APB SETUP/ACCESS sequence per accepted AHB transfer.
// Latency: address phase N, SETUP N+1, ACCESS N+2, data phase completes N+3 plus APB wait states (+1 on error).
// Backpressure: HREADYOUT is held low while the APB slave stalls with PREADY; PSLVERR becomes a two-cycle ERROR.
module ahb_to_apb_bridge #(
    parameter int ADDRWIDTH = 12
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic                 HREADY,
    input  logic [31:0]          HWDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic                 PREADY,
    input  logic [31:0]          PRDATA,
    input  logic                 PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic can_accept;
    logic accept;
    logic rd_capture;

    // Next-cycle values of the registered bus outputs, decoded from state_d.
    logic psel_d;
    logic penable_d;
    logic hreadyout_d;
    logic hresp_d;

    // HSIZE is ignored (all transfers are word-sized); HTRANS[0] only splits NONSEQ/SEQ;
    // HADDR above the APB window and the byte offset are dropped by word alignment.
    logic unused_inputs;
    assign unused_inputs = ^{HSIZE, HTRANS[0], HADDR[31:ADDRWIDTH], HADDR[1:0]};

    // Write data passes straight through; the AHB master holds it while HREADYOUT is low.
    assign PWDATA = HWDATA;

    // A new address phase is only taken when our own data phase is finishing (HREADYOUT high).
    always_comb begin
        can_accept = (state_q == ST_IDLE) || (state_q == ST_ERR2);
        accept     = can_accept && HSEL && HREADY && HTRANS[1];
        rd_capture = (state_q == ST_ACCESS) && PREADY && !PSLVERR && !PWRITE;
    end

    // Next-state decode plus the Moore outputs for the coming cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d = PSLVERR ? ST_ERR1 : ST_IDLE;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                state_d = accept ? ST_SETUP : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    // State register; reset abandons any transfer in flight without reporting it.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered bus handshake outputs so HREADYOUT/PSEL never glitch.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            HREADYOUT <= hreadyout_d;
            HRESP     <= hresp_d;
        end
    end

    // Address and direction are captured only on accept and stay frozen through ACCESS.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
        end else if (accept) begin
            PADDR  <= {HADDR[ADDRWIDTH-1:2], 2'b00};
            PWRITE <= HWRITE;
        end
    end

    // Read data is latched on a clean read completion and held until the next one.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            HRDATA <= '0;
        end else if (rd_capture) begin
            HRDATA <= PRDATA;
        end
    end

endmodule

// File: doc/ahb_to_apb_bridge.md
Name: ahb_to_apb_bridge

Overview:
Single-clock AHB-Lite slave to APB3 master bridge.
Sits between the AHB bus matrix and the APB peripheral segment, including the GPIO/LED peripheral. It converts each AHB-Lite transfer into one APB SETUP/ACCESS sequence.
It stretches the AHB data phase with HREADYOUT until the APB slave completes, and maps PSLVERR onto a two-cycle AHB ERROR response.
PCLK is HCLK; no clock enable.

Parameters:
ADDRWIDTH, 12, width of captured address and PADDR (byte address, bits [ADDRWIDTH-1:0] of HADDR)

Ports:
HCLK  in  1  clock (also clocks APB side)
HRESETn  in  1  reset, synchronous, active-low
HSEL  in  1  bridge selected by AHB decoder
HADDR  in  32  AHB address
HTRANS  in  2  AHB transfer type
HWRITE  in  1  AHB write
HSIZE  in  3  AHB size (ignored; all transfers treated as 32-bit)
HREADY  in  1  AHB bus ready (previous data phase done)
HWDATA  in  32  AHB write data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 OKAY, 1 ERROR
HRDATA  out  32  read data
PADDR  out  ADDRWIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB write
PWDATA  out  32  APB write data
PREADY  in  1  APB ready
PRDATA  in  32  APB read data
PSLVERR  in  1  APB error

Behaviour:
- Only the clock is HCLK. Reset is synchronous, active-low (HRESETn sampled at posedge HCLK); no asynchronous reset anywhere.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0.
- Accept condition, sampled at posedge: HSEL & HREADY & HTRANS[1].
  - On accept, register HADDR[ADDRWIDTH-1:0] into PADDR and HWRITE into PWRITE.
  - Word-align: PADDR[1:0] forced to 0.
- HTRANS IDLE/BUSY, or HSEL=0: no APB activity; zero-wait OKAY.
- States:
  - IDLE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Accept -> SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. Always -> ACCESS next cycle.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0. Hold while PREADY=0. On PREADY=1:
    - PSLVERR=0 -> IDLE; capture PRDATA into HRDATA if read.
    - PSLVERR=1 -> ERR1.
  - ERR1: PSEL=0, HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: PSEL=0, HREADYOUT=1, HRESP=1 -> IDLE. An accept in ERR2 goes directly to SETUP (back-to-back).
- HREADYOUT is registered: it is 1 only in IDLE and ERR2.
- Latency: address phase at cycle N; SETUP N+1; ACCESS N+2.
  - With PREADY=1 at N+2, HREADYOUT=1 at N+3 with HRDATA valid.
  - Minimum 3-cycle data phase; each PREADY=0 cycle adds 1.
- PWDATA = HWDATA combinationally. AHB holds HWDATA stable while HREADYOUT=0, so PWDATA is stable through SETUP/ACCESS.
- PADDR/PWRITE stay stable from SETUP through the end of ACCESS. They are not updated on a non-accepted cycle.
- HRDATA holds its last captured read value. It is not updated by writes or errors.
- Back-to-back: a transfer accepted in the IDLE completion cycle (HREADYOUT=1) starts SETUP on the next cycle. No extra idle cycle between APB transfers.
- Reset asserted mid-transfer: next edge forces IDLE and deasserts PSEL/PENABLE. No partial completion is reported.
- PREADY/PRDATA/PSLVERR are ignored outside ACCESS.

Test Plan:
1. Write 0x0000_00A5 to HADDR 0x4000_0000, PREADY=1.
   - SETUP at N+1 (PSEL=1, PENABLE=0, PADDR=0x000, PWRITE=1, PWDATA=0xA5).
   - ACCESS at N+2; HREADYOUT=1, HRESP=0 at N+3.
2. Read HADDR 0x4000_0004, PRDATA=0x1234_5678, PREADY low 2 cycles.
   - ACCESS held 3 cycles; HREADYOUT=1 at N+5 with HRDATA=0x1234_5678.
3. Write with PSLVERR=1, PREADY=1 in ACCESS.
   - ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. Then IDLE with HRESP=0.
4. Back-to-back write to 0x000 then read from 0x004.
   - Second SETUP starts the cycle after the first completion. PADDR changes 0x000 -> 0x004 only at the second SETUP.
5. HTRANS=IDLE, then BUSY, then HSEL=0 with HTRANS=NONSEQ.
   - PSEL stays 0; HREADYOUT stays 1; HRESP=0.
6. HRESETn low during ACCESS with PREADY=0.
   - Next edge: PSEL=0, PENABLE=0, HREADYOUT=1, HRDATA=0. A new transfer after release completes normally.
